// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with per-channel double-buffered duty cycles, a clock
// prescaler and an edge- or center-aligned phase counter, written through a byte-wide port.
module pwm_bank #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam int NB   = (NUM_CH + 7) / 8;
    localparam int MAXV = (1 << CNT_W) - 1;

    localparam logic [CNT_W:0] MAXV_P      = (CNT_W+1)'(MAXV);
    localparam logic [CNT_W:0] EDGE_LAST   = (CNT_W+1)'(MAXV - 1);
    localparam logic [CNT_W:0] CENTER_LAST = (CNT_W+1)'(2 * MAXV - 1);

    localparam logic [7:0] ADDR_EN_OUT   = 8'h00;
    localparam logic [7:0] ADDR_EN_PWM   = 8'h10;
    localparam logic [7:0] ADDR_PRESCALE = 8'h20;
    localparam logic [7:0] ADDR_MODE     = 8'h21;
    localparam logic [7:0] ADDR_DUTY     = 8'h40;

    logic [NUM_CH-1:0] enOut_q, enOut_d;
    logic [NUM_CH-1:0] enPwm_q, enPwm_d;
    logic [7:0]        prescale_q, prescale_d;
    logic              mode_q, mode_d;
    logic [7:0]        preCnt_q, preCnt_d;
    logic [CNT_W:0]    phase_q, phase_d;
    logic [CNT_W-1:0]  dutyShadow_q [NUM_CH];
    logic [CNT_W-1:0]  dutyShadow_d [NUM_CH];
    logic [CNT_W-1:0]  dutyActive_q [NUM_CH];
    logic [CNT_W-1:0]  dutyActive_d [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic              periodStart_q, periodStart_d;

    logic [NB*8-1:0]   enOutPad;
    logic [NB*8-1:0]   enPwmPad;
    logic              tick;
    logic              wrap;
    logic              modeWr;
    logic              loadDuty;
    logic [CNT_W:0]    phaseLast;
    logic [CNT_W:0]    fold;
    logic [CNT_W:0]    dutyExt;
    logic [NUM_CH-1:0] pwm;

    // Register file writes; enable vectors are padded to whole bytes so bits beyond NUM_CH drop out.
    always_comb begin
        enOutPad   = '0;
        enPwmPad   = '0;
        enOutPad[NUM_CH-1:0] = enOut_q;
        enPwmPad[NUM_CH-1:0] = enPwm_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        modeWr     = 1'b0;

        for (int b = 0; b < NB; b++) begin
            if (wr_en && wr_addr == ADDR_EN_OUT + 8'(b)) begin
                enOutPad[b*8 +: 8] = wr_data;
            end
            if (wr_en && wr_addr == ADDR_EN_PWM + 8'(b)) begin
                enPwmPad[b*8 +: 8] = wr_data;
            end
        end
        enOut_d = enOutPad[NUM_CH-1:0];
        enPwm_d = enPwmPad[NUM_CH-1:0];

        if (wr_en && wr_addr == ADDR_PRESCALE) begin
            prescale_d = wr_data;
        end
        if (wr_en && wr_addr == ADDR_MODE) begin
            mode_d = wr_data[0];
            modeWr = 1'b1;
        end

        for (int ch = 0; ch < NUM_CH; ch++) begin
            dutyShadow_d[ch] = dutyShadow_q[ch];
            if (wr_en && wr_addr == ADDR_DUTY + 8'(ch)) begin
                dutyShadow_d[ch] = wr_data[CNT_W-1:0];
            end
        end
    end

    // Prescaler and phase counter; a mode write restarts both and forces a duty load.
    always_comb begin
        tick      = (preCnt_q == prescale_q);
        preCnt_d  = tick ? 8'd0 : preCnt_q + 8'd1;
        phaseLast = mode_q ? CENTER_LAST : EDGE_LAST;
        wrap      = tick && (phase_q >= phaseLast);
        phase_d   = phase_q;
        if (tick) begin
            phase_d = wrap ? '0 : phase_q + 1'b1;
        end
        if (modeWr) begin
            phase_d  = '0;
            preCnt_d = 8'd0;
        end
        loadDuty      = wrap || modeWr;
        periodStart_d = loadDuty;

        // Loading from the next-state shadow lets a write on the boundary cycle pass straight through.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dutyActive_d[ch] = loadDuty ? dutyShadow_d[ch] : dutyActive_q[ch];
        end
    end

    // Output level per channel from the current phase, duty and enables.
    always_comb begin
        fold    = (phase_q < MAXV_P) ? phase_q : CENTER_LAST - phase_q;
        dutyExt = '0;
        pwm     = '0;
        out_d   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dutyExt = {1'b0, dutyActive_q[ch]};
            if (mode_q) begin
                pwm[ch] = (fold >= MAXV_P - dutyExt);
            end else begin
                pwm[ch] = (phase_q < dutyExt);
            end
            out_d[ch] = enOut_q[ch] & (~enPwm_q[ch] | pwm[ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enOut_q       <= '0;
            enPwm_q       <= '0;
            prescale_q    <= '0;
            mode_q        <= 1'b0;
            preCnt_q      <= '0;
            phase_q       <= '0;
            out_q         <= '0;
            periodStart_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                dutyShadow_q[ch] <= '0;
                dutyActive_q[ch] <= '0;
            end
        end else begin
            enOut_q       <= enOut_d;
            enPwm_q       <= enPwm_d;
            prescale_q    <= prescale_d;
            mode_q        <= mode_d;
            preCnt_q      <= preCnt_d;
            phase_q       <= phase_d;
            out_q         <= out_d;
            periodStart_q <= periodStart_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                dutyShadow_q[ch] <= dutyShadow_d[ch];
                dutyActive_q[ch] <= dutyActive_d[ch];
            end
        end
    end

    assign out          = out_q;
    assign period_start = periodStart_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank with 16 channels and 8-bit resolution; each task covers
// one feature and compares against hand-computed cycle counts.
module tb_pwm_bank;

    logic        clk;
    logic        rst;
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [7:0]  wrData;
    logic [15:0] out;
    logic        periodStart;

    int assertCount;
    int failCount;

    pwm_bank #(.NUM_CH(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wrEn),
        .wr_addr      (wrAddr),
        .wr_data      (wrData),
        .out          (out),
        .period_start (periodStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so the DUT samples them cleanly on the next rising edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wrEn   = 1'b1;
        wrAddr = a;
        wrData = d;
        @(negedge clk);
        wrEn   = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst  = 1'b1;
        wrEn = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    // Counts falling edges until period_start is seen; an expired bound counts as a failure.
    task automatic waitPs(output int n);
        n = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (periodStart === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL period_start_timeout: got no pulse, expected one within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        wrEn   = 1'b1;
        wrAddr = 8'h00;
        wrData = 8'hFF;
        @(negedge clk);
        wrAddr = 8'h01;
        @(negedge clk);
        assertCount++;
        if (out !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_out: got %h expected %h", out, 16'h0000);
        end
        assertCount++;
        if (periodStart !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_period_start: got %b expected 0", periodStart);
        end
        rst  = 1'b0;
        wrEn = 1'b0;
        repeat (3) @(negedge clk);
        assertCount++;
        if (out !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_writes_dropped: got %h expected %h", out, 16'h0000);
        end
    endtask

    task automatic test_static();
        doReset();
        wr(8'h00, 8'hFF);
        wr(8'h01, 8'hFF);
        @(negedge clk);
        assertCount++;
        if (out !== 16'hFFFF) begin
            failCount++;
            $display("[TB] FAIL static_all_high: got %h expected %h", out, 16'hFFFF);
        end
        wr(8'h01, 8'h00);
        @(negedge clk);
        assertCount++;
        if (out !== 16'h00FF) begin
            failCount++;
            $display("[TB] FAIL static_byte1_clear: got %h expected %h", out, 16'h00FF);
        end
        wr(8'h02, 8'hFF);
        wr(8'h12, 8'hFF);
        @(negedge clk);
        assertCount++;
        if (out !== 16'h00FF) begin
            failCount++;
            $display("[TB] FAIL static_unmapped: got %h expected %h", out, 16'h00FF);
        end
        wr(8'h10, 8'h0F);
        @(negedge clk);
        assertCount++;
        if (out !== 16'h00F0) begin
            failCount++;
            $display("[TB] FAIL static_pwm_duty0: got %h expected %h", out, 16'h00F0);
        end
    endtask

    task automatic test_edge();
        int n;
        int highs;
        int lowCh;
        int duties [3] = '{128, 0, 255};
        doReset();
        wr(8'h00, 8'h08);
        wr(8'h10, 8'h08);
        for (int t = 0; t < 3; t++) begin
            wr(8'h43, 8'(duties[t]));
            waitPs(n);
            highs = 0;
            lowCh = 0;
            for (int k = 1; k <= 255; k++) begin
                @(negedge clk);
                if (out[3] === 1'b1) highs++;
                if (out[2] !== 1'b0) lowCh++;
            end
            assertCount++;
            if (highs != duties[t]) begin
                failCount++;
                $display("[TB] FAIL edge_duty%0d_high: got %0d expected %0d", duties[t], highs, duties[t]);
            end
            assertCount++;
            if (lowCh != 0) begin
                failCount++;
                $display("[TB] FAIL edge_disabled_ch2: got %0d nonzero cycles expected 0", lowCh);
            end
        end
    endtask

    task automatic test_center();
        int n;
        int highs;
        int first;
        int last;
        doReset();
        wr(8'h00, 8'h01);
        wr(8'h10, 8'h01);
        wr(8'h40, 8'd64);
        wr(8'h21, 8'h01);
        assertCount++;
        if (periodStart !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL center_mode_write_pulse: got %b expected 1", periodStart);
        end
        highs = 0;
        first = -1;
        last  = -1;
        for (int k = 1; k <= 510; k++) begin
            @(negedge clk);
            if (out[0] === 1'b1) begin
                highs++;
                if (first < 0) first = k - 1;
                last = k - 1;
            end
        end
        assertCount++;
        if (highs != 128) begin
            failCount++;
            $display("[TB] FAIL center_high: got %0d expected 128", highs);
        end
        assertCount++;
        if (first != 191 || last != 318) begin
            failCount++;
            $display("[TB] FAIL center_window: got %0d..%0d expected 191..318", first, last);
        end
        waitPs(n);
        assertCount++;
        if (n != 510) begin
            failCount++;
            $display("[TB] FAIL center_spacing: got %0d expected 510", n);
        end
    endtask

    task automatic test_shadow();
        int n;
        int highs;
        logic psSeen;
        doReset();
        wr(8'h00, 8'h01);
        wr(8'h10, 8'h01);
        wr(8'h40, 8'd32);
        waitPs(n);
        highs  = 0;
        psSeen = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (out[0] === 1'b1) highs++;
            if (k == 255) psSeen = periodStart;
            if (k == 100) begin
                wrEn   = 1'b1;
                wrAddr = 8'h40;
                wrData = 8'd200;
            end
            if (k == 101) wrEn = 1'b0;
        end
        assertCount++;
        if (highs != 32) begin
            failCount++;
            $display("[TB] FAIL shadow_old_period: got %0d expected 32", highs);
        end
        assertCount++;
        if (psSeen !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL shadow_boundary_pulse: got %b expected 1", psSeen);
        end
        highs = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (out[0] === 1'b1) highs++;
            if (k == 254) begin
                wrEn   = 1'b1;
                wrAddr = 8'h40;
                wrData = 8'd10;
            end
            if (k == 255) wrEn = 1'b0;
        end
        assertCount++;
        if (highs != 200) begin
            failCount++;
            $display("[TB] FAIL shadow_new_period: got %0d expected 200", highs);
        end
        highs = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (out[0] === 1'b1) highs++;
        end
        assertCount++;
        if (highs != 10) begin
            failCount++;
            $display("[TB] FAIL shadow_write_through: got %0d expected 10", highs);
        end
    endtask

    task automatic test_prescale_reset();
        int n;
        int highs;
        doReset();
        wr(8'h20, 8'h03);
        wr(8'h00, 8'h08);
        wr(8'h10, 8'h08);
        wr(8'h43, 8'd128);
        waitPs(n);
        waitPs(n);
        assertCount++;
        if (n != 1020) begin
            failCount++;
            $display("[TB] FAIL prescale_spacing: got %0d expected 1020", n);
        end
        highs = 0;
        for (int k = 1; k <= 1020; k++) begin
            @(negedge clk);
            if (out[3] === 1'b1) highs++;
        end
        assertCount++;
        if (highs != 512) begin
            failCount++;
            $display("[TB] FAIL prescale_high: got %0d expected 512", highs);
        end
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        assertCount++;
        if (out !== 16'h0000 || periodStart !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midperiod_reset: got out=%h ps=%b expected out=0000 ps=0", out, periodStart);
        end
        rst = 1'b0;
        waitPs(n);
        assertCount++;
        if (n != 255) begin
            failCount++;
            $display("[TB] FAIL reset_restart_spacing: got %0d expected 255", n);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst    = 1'b1;
        wrEn   = 1'b0;
        wrAddr = 8'h00;
        wrData = 8'h00;
        test_reset();
        test_static();
        test_edge();
        test_center();
        test_shadow();
        test_prescale_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
